// File: rtl/extrema_pkg.sv
// extrema_pkg: shared types and neighbourhood constants for the extrema scanner
package extrema_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EVAL} state_t;
  localparam int NEIGHBOURS = 9;
  localparam int CENTRE_IDX = 4;
  localparam int OTHERS = 2 * NEIGHBOURS - 1;
  localparam int K_W = 4;
  localparam int DX [NEIGHBOURS] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};
  localparam int DY [NEIGHBOURS] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
endpackage

// File: rtl/extrema_compare.sv
// extrema_compare: strict signed compare of a centre sample against all 17 neighbours
module extrema_compare
  import extrema_pkg::*;
#(
  parameter int BIT_DEPTH = 9
) (
  input  logic signed [BIT_DEPTH-1:0] centre,
  input  logic signed [BIT_DEPTH-1:0] others [OTHERS],
  output logic                        is_max,
  output logic                        is_min
);
  // any tie with a neighbour clears both flags
  always_comb begin
    is_max = 1'b1;
    is_min = 1'b1;
    for (int i = 0; i < OTHERS; i++) begin
      is_max = is_max & (centre > others[i]);
      is_min = is_min & (centre < others[i]);
    end
  end
endmodule

// File: rtl/extrema_scan_ctrl.sv
// extrema_scan_ctrl: sweeps interior pixels of a DoG layer pair and flags local extrema
module extrema_scan_ctrl
  import extrema_pkg::*;
#(
  parameter int BIT_DEPTH = 9,
  parameter int DIMENSION = 4,
  parameter int READ_LATENCY = 2,
  localparam int AW = $clog2(DIMENSION * DIMENSION),
  localparam int CW = $clog2(DIMENSION)
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        start,
  output logic [AW-1:0]               first_address,
  input  logic signed [BIT_DEPTH-1:0] first_data,
  output logic [AW-1:0]               second_address,
  input  logic signed [BIT_DEPTH-1:0] second_data,
  output logic                        keypoint_valid,
  output logic [CW-1:0]               keypoint_x,
  output logic [CW-1:0]               keypoint_y,
  output logic                        busy,
  output logic                        done
);
  if (DIMENSION < 3) begin : g_dim_check
    $error("extrema_scan_ctrl: DIMENSION must be >= 3");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 16) begin : g_lat_check
    $error("extrema_scan_ctrl: READ_LATENCY must be 1..16");
  end
  state_t state, state_n;
  logic [CW-1:0] x, y, x_n, y_n, kx_n, ky_n;
  logic [K_W-1:0] k, k_n, k_idx;
  logic kv_n, done_n, last, is_max, is_min;
  logic [K_W-1:0] kd [READ_LATENCY];
  logic [READ_LATENCY-1:0] vd;
  logic signed [BIT_DEPTH-1:0] s1 [NEIGHBOURS];
  logic signed [BIT_DEPTH-1:0] s2 [NEIGHBOURS];
  logic signed [BIT_DEPTH-1:0] others [OTHERS];
  assign busy = state != IDLE;
  assign second_address = first_address;
  assign k_idx = k < K_W'(NEIGHBOURS) ? k : '0;
  assign last = x == CW'(DIMENSION - 2) && y == CW'(DIMENSION - 2);
  // neighbourhood address, only driven while issuing reads
  always_comb begin
    first_address = state == ISSUE
      ? AW'((int'(y) + DY[k_idx]) * DIMENSION + int'(x) + DX[k_idx]) : '0;
  end
  // every sample except the first-layer centre, both layers
  always_comb begin
    for (int i = 0; i < NEIGHBOURS - 1; i++) others[i] = s1[i < CENTRE_IDX ? i : i + 1];
    for (int i = 0; i < NEIGHBOURS; i++) others[NEIGHBOURS - 1 + i] = s2[i];
  end
  extrema_compare #(.BIT_DEPTH(BIT_DEPTH)) u_compare (
    .centre(s1[CENTRE_IDX]),
    .others(others),
    .is_max(is_max),
    .is_min(is_min)
  );
  // next-state, counter advance and keypoint/done pulse generation
  always_comb begin
    state_n = state;
    x_n = x;
    y_n = y;
    k_n = k;
    kx_n = keypoint_x;
    ky_n = keypoint_y;
    kv_n = 1'b0;
    done_n = 1'b0;
    unique case (state)
      IDLE: begin
        state_n = start ? ISSUE : IDLE;
        x_n = start ? CW'(1) : x;
        y_n = start ? CW'(1) : y;
        k_n = '0;
      end
      ISSUE: begin
        state_n = k == K_W'(NEIGHBOURS - 1) ? WAIT : ISSUE;
        k_n = k == K_W'(NEIGHBOURS - 1) ? '0 : k + 1'b1;
      end
      WAIT: begin
        state_n = k == K_W'(READ_LATENCY - 1) ? EVAL : WAIT;
        k_n = k == K_W'(READ_LATENCY - 1) ? '0 : k + 1'b1;
      end
      EVAL: begin
        kv_n = is_max | is_min;
        kx_n = kv_n ? x : keypoint_x;
        ky_n = kv_n ? y : keypoint_y;
        done_n = last;
        state_n = last ? IDLE : ISSUE;
        k_n = '0;
        x_n = x == CW'(DIMENSION - 2) ? CW'(1) : x + 1'b1;
        y_n = x == CW'(DIMENSION - 2) ? y + 1'b1 : y;
      end
      default: state_n = IDLE;
    endcase
  end
  // FSM, scan counters and registered outputs
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
      x <= '0;
      y <= '0;
      k <= '0;
      keypoint_valid <= 1'b0;
      keypoint_x <= '0;
      keypoint_y <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      x <= x_n;
      y <= y_n;
      k <= k_n;
      keypoint_valid <= kv_n;
      keypoint_x <= kx_n;
      keypoint_y <= ky_n;
      done <= done_n;
    end
  end
  // offset index follows each read through the BRAM latency and steers the returned samples
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      vd <= '0;
      for (int i = 0; i < READ_LATENCY; i++) kd[i] <= '0;
      for (int i = 0; i < NEIGHBOURS; i++) begin
        s1[i] <= '0;
        s2[i] <= '0;
      end
    end else begin
      vd[0] <= state == ISSUE;
      kd[0] <= k;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vd[i] <= vd[i-1];
        kd[i] <= kd[i-1];
      end
      if (vd[READ_LATENCY-1]) begin
        s1[kd[READ_LATENCY-1]] <= first_data;
        s2[kd[READ_LATENCY-1]] <= second_data;
      end
    end
  end
endmodule

// File: tb/tb_extrema_scan_ctrl.sv
// tb_extrema_scan_ctrl: directed checks of the extrema scan controller with BRAM models
module tb_extrema_scan_ctrl;
  localparam int BD = 9;
  localparam int D = 4;
  localparam int AW = 4;
  localparam int CW = 2;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic start = 1'b0;
  logic [AW-1:0] first_address, second_address;
  logic signed [BD-1:0] first_data, second_data, p1, p2;
  logic keypoint_valid, busy, done;
  logic [CW-1:0] keypoint_x, keypoint_y;
  logic signed [BD-1:0] mem1 [D*D];
  logic signed [BD-1:0] mem2 [D*D];
  logic clr = 1'b1;
  int cyc, busy_cnt, done_cnt, kv_cnt, kv_cyc, done_cyc, addr_err;
  logic [AW-1:0] addr_log [10];
  int checks = 0;
  int errors = 0;

  extrema_scan_ctrl #(.BIT_DEPTH(BD), .DIMENSION(D), .READ_LATENCY(2)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .start(start),
    .first_address(first_address),
    .first_data(first_data),
    .second_address(second_address),
    .second_data(second_data),
    .keypoint_valid(keypoint_valid),
    .keypoint_x(keypoint_x),
    .keypoint_y(keypoint_y),
    .busy(busy),
    .done(done)
  );

  always #5 clk_in = ~clk_in;

  // two-cycle read latency BRAM pair
  always @(posedge clk_in) begin
    p1 <= mem1[first_address];
    p2 <= mem2[second_address];
    first_data <= p1;
    second_data <= p2;
  end

  // per-scan observation, sampled mid-cycle; cyc=j+1 in scan cycle n+j
  always @(negedge clk_in) begin
    if (clr) begin
      cyc <= 0;
      busy_cnt <= 0;
      done_cnt <= 0;
      kv_cnt <= 0;
      kv_cyc <= -1;
      done_cyc <= -1;
      addr_err <= 0;
    end else begin
      cyc <= cyc + 1;
      if (busy) busy_cnt <= busy_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (keypoint_valid) kv_cnt <= kv_cnt + 1;
      if (keypoint_valid && kv_cnt == 0) kv_cyc <= cyc + 1;
      if (done && done_cnt == 0) done_cyc <= cyc + 1;
      if (first_address !== second_address) addr_err <= addr_err + 1;
      if (cyc < 9) addr_log[cyc+1] <= first_address;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic clear_mem;
    foreach (mem1[i]) begin
      mem1[i] = '0;
      mem2[i] = '0;
    end
  endtask

  task automatic begin_scan;
    clr = 1'b1;
    start = 1'b1;
    tick(1);
    clr = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    tick(4);
  endtask

  task automatic test_reset;
    rst_in = 1'b1;
    clr = 1'b1;
    tick(2);
    checks += 6;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    if (keypoint_valid !== 1'b0) begin errors++; $display("FAIL reset_kv got %0b want 0", keypoint_valid); end
    if (keypoint_x !== 2'd0) begin errors++; $display("FAIL reset_kx got %0d want 0", keypoint_x); end
    if (keypoint_y !== 2'd0) begin errors++; $display("FAIL reset_ky got %0d want 0", keypoint_y); end
    if (first_address !== 4'd0 || second_address !== 4'd0) begin
      errors++; $display("FAIL reset_addr got %0d/%0d want 0/0", first_address, second_address);
    end
    rst_in = 1'b0;
    tick(2);
  endtask

  task automatic test_all_zero;
    bit ok;
    clear_mem();
    begin_scan();
    wait_done(ok);
    checks += 6;
    if (!ok) begin errors++; $display("FAIL zero_timeout got no done want done within 200 cycles"); end
    if (busy_cnt != 48) begin errors++; $display("FAIL zero_busy_cycles got %0d want 48", busy_cnt); end
    if (done_cnt != 1) begin errors++; $display("FAIL zero_done_count got %0d want 1", done_cnt); end
    if (kv_cnt != 0) begin errors++; $display("FAIL zero_kv_count got %0d want 0", kv_cnt); end
    if (done_cyc != 49) begin errors++; $display("FAIL zero_done_cycle got %0d want 49", done_cyc); end
    if (addr_err != 0) begin errors++; $display("FAIL zero_addr_equal got %0d diffs want 0", addr_err); end
  endtask

  task automatic test_single_max;
    bit ok;
    int exp_addr [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    clear_mem();
    mem1[5] = 9'sd100;
    begin_scan();
    wait_done(ok);
    checks += 6;
    if (!ok) begin errors++; $display("FAIL max_timeout got no done want done within 200 cycles"); end
    if (kv_cnt != 1) begin errors++; $display("FAIL max_kv_count got %0d want 1", kv_cnt); end
    if (kv_cyc != 13) begin errors++; $display("FAIL max_kv_cycle got %0d want 13", kv_cyc); end
    if (keypoint_x !== 2'd1) begin errors++; $display("FAIL max_kx got %0d want 1", keypoint_x); end
    if (keypoint_y !== 2'd1) begin errors++; $display("FAIL max_ky got %0d want 1", keypoint_y); end
    if (done_cnt != 1) begin errors++; $display("FAIL max_done_count got %0d want 1", done_cnt); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (addr_log[i+1] !== AW'(exp_addr[i])) begin
        errors++; $display("FAIL max_addr_k%0d got %0d want %0d", i, addr_log[i+1], exp_addr[i]);
      end
    end
  endtask

  task automatic test_single_min;
    bit ok;
    clear_mem();
    mem1[10] = -9'sd200;
    begin_scan();
    wait_done(ok);
    checks += 7;
    if (!ok) begin errors++; $display("FAIL min_timeout got no done want done within 200 cycles"); end
    if (kv_cnt != 1) begin errors++; $display("FAIL min_kv_count got %0d want 1", kv_cnt); end
    if (keypoint_x !== 2'd2) begin errors++; $display("FAIL min_kx got %0d want 2", keypoint_x); end
    if (keypoint_y !== 2'd2) begin errors++; $display("FAIL min_ky got %0d want 2", keypoint_y); end
    if (kv_cyc != 49) begin errors++; $display("FAIL min_kv_cycle got %0d want 49", kv_cyc); end
    if (done_cyc != 49) begin errors++; $display("FAIL min_done_cycle got %0d want 49", done_cyc); end
    if (busy_cnt != 48) begin errors++; $display("FAIL min_busy_cycles got %0d want 48", busy_cnt); end
  endtask

  task automatic test_tie;
    bit ok;
    clear_mem();
    mem1[5] = 9'sd100;
    mem2[5] = 9'sd100;
    begin_scan();
    wait_done(ok);
    checks += 4;
    if (!ok) begin errors++; $display("FAIL tie_timeout got no done want done within 200 cycles"); end
    if (kv_cnt != 0) begin errors++; $display("FAIL tie_kv_count got %0d want 0", kv_cnt); end
    if (done_cnt != 1) begin errors++; $display("FAIL tie_done_count got %0d want 1", done_cnt); end
    if (addr_err != 0) begin errors++; $display("FAIL tie_addr_equal got %0d diffs want 0", addr_err); end
  endtask

  task automatic test_start_ignored;
    clear_mem();
    mem1[5] = 9'sd100;
    begin_scan();
    for (int i = 0; i < 60; i++) begin
      start = (i == 5 || i == 20);
      tick(1);
    end
    start = 1'b0;
    checks += 3;
    if (busy_cnt != 48) begin errors++; $display("FAIL ign_busy_cycles got %0d want 48", busy_cnt); end
    if (done_cnt != 1) begin errors++; $display("FAIL ign_done_count got %0d want 1", done_cnt); end
    if (kv_cnt != 1) begin errors++; $display("FAIL ign_kv_count got %0d want 1", kv_cnt); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    clear_mem();
    mem1[5] = 9'sd100;
    begin_scan();
    tick(16);
    rst_in = 1'b1;
    #1;
    checks += 5;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %0b want 0", busy); end
    if (keypoint_valid !== 1'b0) begin errors++; $display("FAIL mid_kv got %0b want 0", keypoint_valid); end
    if (done !== 1'b0) begin errors++; $display("FAIL mid_done got %0b want 0", done); end
    if (keypoint_x !== 2'd0 || keypoint_y !== 2'd0) begin
      errors++; $display("FAIL mid_kxy got %0d,%0d want 0,0", keypoint_x, keypoint_y);
    end
    if (first_address !== 4'd0) begin errors++; $display("FAIL mid_addr got %0d want 0", first_address); end
    tick(2);
    rst_in = 1'b0;
    tick(10);
    checks += 3;
    if (done_cnt != 0) begin errors++; $display("FAIL mid_no_done got %0d want 0", done_cnt); end
    if (kv_cnt != 1) begin errors++; $display("FAIL mid_kv_count got %0d want 1", kv_cnt); end
    if (busy_cnt != 16) begin errors++; $display("FAIL mid_busy_cycles got %0d want 16", busy_cnt); end
    begin_scan();
    wait_done(ok);
    checks += 5;
    if (!ok) begin errors++; $display("FAIL restart_timeout got no done want done within 200 cycles"); end
    if (kv_cnt != 1) begin errors++; $display("FAIL restart_kv_count got %0d want 1", kv_cnt); end
    if (kv_cyc != 13) begin errors++; $display("FAIL restart_kv_cycle got %0d want 13", kv_cyc); end
    if (keypoint_x !== 2'd1 || keypoint_y !== 2'd1) begin
      errors++; $display("FAIL restart_kxy got %0d,%0d want 1,1", keypoint_x, keypoint_y);
    end
    if (done_cnt != 1) begin errors++; $display("FAIL restart_done_count got %0d want 1", done_cnt); end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_all_zero();
    test_single_max();
    test_single_min();
    test_tie();
    test_start_ignored();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
